// File: rtl/spsram_swap_ctrl.sv
// spsram_swap_ctrl
//
// Sits between a host and two single-port SRAM banks (A and B) and swaps
// their entire contents on request. When idle, every bank-side signal
// mirrors the matching host signal, so the host uses the banks directly.
// A start pulse runs an RD/WR pair for each address. RD reads both banks
// at idx. WR writes each bank with the word that was just read from the
// other bank. A final DONE cycle follows the last pair. Host traffic is
// dropped for the whole sequence.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   start              swap request, honoured only when idle
//   busy, done         sequence in progress / one-cycle completion pulse
//   h_cs_*, h_we_*     host chip-select / write-enable per bank
//   h_ad_*, h_wd_*     host address / write data per bank
//   cs_*, we_*         bank chip-select / write-enable
//   ad_*, wd_*         bank address / write data
//   rd_*               bank read data (one cycle after a read access)
//   state_dbg          current FSM state, for observation only
//
// Handshake: there is no valid/ready pair. start is a level that is
// sampled on the clock edges where the controller is idle. A start seen
// while busy is high is discarded, not remembered.

module spsram_swap_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 h_cs_a,
  input  logic                 h_we_a,
  input  logic                 h_cs_b,
  input  logic                 h_we_b,
  input  logic [DEPTH_LOG-1:0] h_ad_a,
  input  logic [DEPTH_LOG-1:0] h_ad_b,
  input  logic [WIDTH-1:0]     h_wd_a,
  input  logic [WIDTH-1:0]     h_wd_b,
  output logic                 cs_a,
  output logic                 we_a,
  output logic                 cs_b,
  output logic                 we_b,
  output logic [DEPTH_LOG-1:0] ad_a,
  output logic [DEPTH_LOG-1:0] ad_b,
  output logic [WIDTH-1:0]     wd_a,
  output logic [WIDTH-1:0]     wd_b,
  input  logic [WIDTH-1:0]     rd_a,
  input  logic [WIDTH-1:0]     rd_b,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [DEPTH_LOG-1:0] LAST_IDX = DEPTH_LOG'(DEPTH - 1);

  state_t               state, state_nx;
  logic [DEPTH_LOG-1:0] idx, idx_nx;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    busy     = 1'b0;
    done     = 1'b0;
    cs_a     = 1'b0;
    we_a     = 1'b0;
    cs_b     = 1'b0;
    we_b     = 1'b0;
    ad_a     = '0;
    ad_b     = '0;
    wd_a     = '0;
    wd_b     = '0;

    case (state)
      IDLE: begin
        // Reset is asynchronous, so the state register reads IDLE for as
        // long as rst is high. The strobes are gated with rst so that the
        // host cannot reach the banks while reset is asserted.
        cs_a = h_cs_a & ~rst;
        we_a = h_we_a & ~rst;
        cs_b = h_cs_b & ~rst;
        we_b = h_we_b & ~rst;
        ad_a = h_ad_a;
        ad_b = h_ad_b;
        wd_a = h_wd_a;
        wd_b = h_wd_b;
        if (start) begin
          state_nx = RD;
          idx_nx   = '0;
        end
      end

      RD: begin
        busy     = 1'b1;
        cs_a     = 1'b1;
        cs_b     = 1'b1;
        ad_a     = idx;
        ad_b     = idx;
        state_nx = WR;
      end

      WR: begin
        // rd_* returns the words fetched in the preceding RD cycle. Each
        // word is written back into the opposite bank at the same address.
        busy = 1'b1;
        cs_a = 1'b1;
        we_a = 1'b1;
        cs_b = 1'b1;
        we_b = 1'b1;
        ad_a = idx;
        ad_b = idx;
        wd_a = rd_b;
        wd_b = rd_a;
        if (idx == LAST_IDX) begin
          state_nx = DONE;
          idx_nx   = '0;
        end else begin
          state_nx = RD;
          idx_nx   = idx + DEPTH_LOG'(1);
        end
      end

      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

endmodule
